// File: rtl/myproject_mul_pipe_ce.sv
// Pipelined multiplier with clock enable, per-operand signedness and optional
// saturation when narrowing the product into dout.
module myproject_mul_pipe_ce #(
  parameter int ID          = 1,
  parameter int NUM_STAGE   = 2,
  parameter int din0_WIDTH  = 14,
  parameter int din1_WIDTH  = 12,
  parameter int dout_WIDTH  = 26,
  parameter int din0_SIGNED = 1,
  parameter int din1_SIGNED = 0,
  parameter int SAT_MODE    = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  din0_vld,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  dout_vld,
  output logic [dout_WIDTH-1:0] dout,
  output logic                  sat_flag
);

  localparam int P = din0_WIDTH + din1_WIDTH + 1;
  localparam int W = ((dout_WIDTH > P) ? dout_WIDTH : P) + 1;
  localparam bit RES_SIGNED = (din0_SIGNED != 0) || (din1_SIGNED != 0);
  localparam logic signed [W-1:0] LIM_MAX = RES_SIGNED
    ? {{(W-dout_WIDTH+1){1'b0}}, {(dout_WIDTH-1){1'b1}}}
    : {{(W-dout_WIDTH){1'b0}}, {dout_WIDTH{1'b1}}};
  localparam logic signed [W-1:0] LIM_MIN = RES_SIGNED
    ? {{(W-dout_WIDTH+1){1'b1}}, {(dout_WIDTH-1){1'b0}}}
    : '0;
  localparam int unused_id = ID;

  if (NUM_STAGE < 0 || NUM_STAGE > 4 || din0_WIDTH < 2 || din1_WIDTH < 2 || dout_WIDTH < 2) begin : g_param_err
    $error("myproject_mul_pipe_ce ID=%0d: illegal parameter set", ID);
  end

  logic [din0_WIDTH-1:0] w_opa;
  logic [din1_WIDTH-1:0] w_opb;
  logic                  w_a_sx;
  logic                  w_b_sx;
  logic signed [P-1:0]   w_a_ext;
  logic signed [P-1:0]   w_b_ext;
  logic signed [P-1:0]   w_prod;
  logic signed [P-1:0]   w_pfin;
  logic signed [W-1:0]   w_pw;
  logic [dout_WIDTH-1:0] w_res;
  logic                  w_sat;

  // Stage 1 registers the raw operands once the pipe is at least two deep.
  if (NUM_STAGE >= 2) begin : g_in_reg
    logic [din0_WIDTH-1:0] r_a;
    logic [din1_WIDTH-1:0] r_b;
    always_ff @(posedge clk) begin
      if (reset) begin
        r_a <= '0;
        r_b <= '0;
      end else if (ce) begin
        r_a <= din0;
        r_b <= din1;
      end
    end
    assign w_opa = r_a;
    assign w_opb = r_b;
  end else begin : g_in_comb
    assign w_opa = din0;
    assign w_opb = din1;
  end

  assign w_a_sx  = (din0_SIGNED != 0) && w_opa[din0_WIDTH-1];
  assign w_b_sx  = (din1_SIGNED != 0) && w_opb[din1_WIDTH-1];
  assign w_a_ext = {{(P-din0_WIDTH){w_a_sx}}, w_opa};
  assign w_b_ext = {{(P-din1_WIDTH){w_b_sx}}, w_opb};
  assign w_prod  = w_a_ext * w_b_ext;

  // Middle stages only delay the full-width product; oldest entry sits at the top.
  if (NUM_STAGE >= 3) begin : g_dly
    localparam int DLY = NUM_STAGE - 2;
    logic [DLY*P-1:0] r_pd;
    always_ff @(posedge clk) begin
      if (reset) begin
        r_pd <= '0;
      end else if (ce) begin
        r_pd <= (DLY*P)'({r_pd, w_prod});
      end
    end
    assign w_pfin = r_pd[DLY*P-1 -: P];
  end else begin : g_nodly
    assign w_pfin = w_prod;
  end

  assign w_pw = {{(W-P){w_pfin[P-1]}}, w_pfin};

  always_comb begin
    w_res = w_pw[dout_WIDTH-1:0];
    w_sat = 1'b0;
    if ((SAT_MODE != 0) && (dout_WIDTH < P)) begin
      if (w_pw > LIM_MAX) begin
        w_res = LIM_MAX[dout_WIDTH-1:0];
        w_sat = 1'b1;
      end else if (w_pw < LIM_MIN) begin
        w_res = LIM_MIN[dout_WIDTH-1:0];
        w_sat = 1'b1;
      end
    end
  end

  if (NUM_STAGE == 0) begin : g_comb_out
    logic w_unused;
    assign w_unused = clk ^ reset ^ ce;
    assign dout_vld = din0_vld;
    assign dout     = w_res;
    assign sat_flag = w_sat;
  end else begin : g_reg_out
    logic [NUM_STAGE-1:0]  r_vld;
    logic [dout_WIDTH-1:0] r_dout;
    logic                  r_sat;
    always_ff @(posedge clk) begin
      if (reset) begin
        r_vld  <= '0;
        r_dout <= '0;
        r_sat  <= 1'b0;
      end else if (ce) begin
        r_vld  <= (NUM_STAGE)'({r_vld, din0_vld});
        r_dout <= w_res;
        r_sat  <= w_sat;
      end
    end
    assign dout_vld = r_vld[NUM_STAGE-1];
    assign dout     = r_dout;
    assign sat_flag = r_sat;
  end

endmodule

// File: doc/myproject_mul_pipe_ce.md
MYPROJECT_MUL_PIPE_CE -- requirements
Module: myproject_mul_pipe_ce

Interface
REQ-001: The block SHALL have these parameters (name, default, meaning):
- ID, 1, instance tag with no functional effect.
- NUM_STAGE, 2, pipeline depth, legal range 0..4.
- din0_WIDTH, 14, width of operand 0.
- din1_WIDTH, 12, width of operand 1.
- dout_WIDTH, 26, width of the result.
- din0_SIGNED, 1, 1 = din0 is two's complement, 0 = unsigned.
- din1_SIGNED, 0, 1 = din1 is two's complement, 0 = unsigned.
- SAT_MODE, 0, 0 = wrap (truncate), 1 = saturate when narrowing.
REQ-002: The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, the single clock.
- reset, in, 1, synchronous, active-high.
- ce, in, 1, clock enable for all pipeline state.
- din0_vld, in, 1, input sample valid.
- din0, in, din0_WIDTH, operand 0.
- din1, in, din1_WIDTH, operand 1.
- dout_vld, out, 1, result valid.
- dout, out, dout_WIDTH, result.
- sat_flag, out, 1, the result aligned with dout was clamped.
REQ-003: The block SHALL use one clock, clk; reset SHALL be synchronous and active-high.

Function
REQ-004: Each operand SHALL be extended by one bit according to its SIGNED parameter (sign-extend if signed, zero-extend if unsigned) before multiplying.
REQ-005: The full product SHALL be computed at width P = din0_WIDTH + din1_WIDTH + 1 and treated as signed.
REQ-006: The result SHALL be treated as signed if either SIGNED parameter is 1, otherwise as unsigned.
REQ-007: If dout_WIDTH >= P, dout SHALL be the exact product extended to dout_WIDTH (sign-extended if the result is signed, zero-extended otherwise); sat_flag SHALL be 0.
REQ-008: If dout_WIDTH < P and SAT_MODE = 0, dout SHALL be the low dout_WIDTH bits of the product, and sat_flag SHALL be 0.
REQ-009: If dout_WIDTH < P and SAT_MODE = 1, a product outside the dout range SHALL clamp to the range limit:
- signed result: max = 2^(dout_WIDTH-1)-1, min = -2^(dout_WIDTH-1).
- unsigned result: max = 2^dout_WIDTH-1, min = 0.
- sat_flag SHALL be 1 for exactly that sample.
REQ-010: For NUM_STAGE = 0 the block SHALL be purely combinational: dout_vld = din0_vld, and ce and reset SHALL have no effect.
REQ-011: For NUM_STAGE = N >= 1, a sample accepted on a clock edge with ce = 1 SHALL appear on dout/dout_vld/sat_flag after exactly N ce-enabled edges.
- Input registration SHALL be stage 1.
- Saturation logic SHALL sit in the final stage.
REQ-012: When ce = 0, every pipeline register, including the valid shift chain, SHALL hold its value; outputs SHALL remain stable.
REQ-013: Data registers SHALL load regardless of din0_vld (ce only). The valid chain SHALL shift din0_vld.
REQ-014: Back-to-back samples SHALL be accepted on every ce-enabled cycle (throughput 1 per ce-enabled cycle) with no bubbles inserted.
REQ-015: dout_vld SHALL be 1 for exactly one ce-enabled cycle per accepted valid sample. Outputs SHALL not change between ce-enabled edges.
REQ-016: If ce = 1 and reset = 1 on the same edge, reset SHALL win.
REQ-017: Parameter values outside the legal range (NUM_STAGE > 4, any width < 2) SHALL trigger a simulation-time $error at elaboration.

Reset
REQ-018: On a reset edge, regardless of ce, all valid-chain bits, dout_vld, sat_flag and dout SHALL become 0. Internal data registers SHALL also clear to 0.
REQ-019: Samples in flight when reset asserts SHALL be discarded and never produce dout_vld.
REQ-020: The first edge after reset deasserts SHALL accept new input normally.

Verification
REQ-021: Defaults; din0 = -8192 (0x2000), din1 = 4095, vld = 1, ce = 1 -> after 2 edges dout = -33546240, dout_vld = 1, sat_flag = 0.
REQ-022: dout_WIDTH = 16, SAT_MODE = 1, defaults otherwise; din0 = 1000, din1 = 100 -> dout = 32767, sat_flag = 1. With din0 = -1000 -> dout = -32768, sat_flag = 1. With SAT_MODE = 0 and din0 = 1000, din1 = 100 -> dout = 100000 mod 65536 = 0x86A0 (wrap), sat_flag = 0.
REQ-023: NUM_STAGE = 3, 5 consecutive valid samples with ce toggling 1,0,1,1,0,1... -> results emerge in order, each exactly 3 ce-enabled edges after acceptance, held stable while ce = 0.
REQ-024: NUM_STAGE = 2; assert reset 1 cycle after 2 valid samples are accepted -> no dout_vld for either sample; outputs read 0; a sample accepted after reset completes correctly.
REQ-025: din0_SIGNED = din1_SIGNED = 0; din0 = 16383, din1 = 4095 -> dout = 67088385, no sign extension. Random regression of 10^5 samples against a reference model for all four signedness combinations and NUM_STAGE 0..4.
